muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Multi-cycle RV32M multiply/divide unit in the execute stage, beside the single-cycle ALU. Takes the ALU_MUL..ALU_REMU codes produced by the ALU control decoder. Iterative shift-add multiply and restoring divide, one bit per cycle. Busy/done handshake lets the hazard unit stall the pipeline while an operation runs.

Parameters:
XLEN, 32, operand/result width (even, >= 8)
FAST_MUL, 0, 1 = MUL/MULH* done with one registered full-width multiply (1-cycle latency); 0 = iterative

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  request; sampled only while busy=0
op  input  5  ALU code: `ALU_MUL, `ALU_MULH, `ALU_MULHSU, `ALU_MULHU, `ALU_DIV, `ALU_DIVU, `ALU_REM, `ALU_REMU
a  input  XLEN  rs1 operand
b  input  XLEN  rs2 operand
flush  input  1  abort the current operation (branch/exception)
busy  output  1  operation in progress; hazard unit stalls on it
done  output  1  one-cycle pulse; result valid
result  output  XLEN  registered result; held until the next accepted start

Behaviour:
- Reset (rst=0, async): state IDLE, busy=0, done=0, result=0, all internal registers 0. Applies mid-operation; no done is produced.
- States: IDLE, CALC, FIX.
- IDLE:
  - done is high only in the cycle after FIX or after a short-path completion.
  - start=1 and valid op: latch op, abs(a), abs(b), sign flags and negate flags; clear bit counter; go to CALC; busy=1.
- Operand signs: MUL/MULH/DIV/REM treat a and b as signed. MULHSU treats a as signed, b as unsigned. MULHU/DIVU/REMU treat both as unsigned.
- CALC: exactly XLEN cycles, counter 0..XLEN-1.
  - Multiply: 2*XLEN-bit product accumulator.
  - Divide: XLEN+1-bit partial remainder, restoring step.
  - At counter XLEN-1, go to FIX.
- FIX (1 cycle):
  - Apply two's-complement negation: product if sign_a^sign_b; quotient if sign_a^sign_b; remainder if sign_a.
  - Select low half (MUL), high half (MULH*), quotient or remainder.
  - Register result, pulse done, busy=0, return to IDLE.
- Latency: start sampled at edge 0. busy is high after edges 1..XLEN+1 (XLEN+1 cycles). done is high for one cycle after edge XLEN+2.
- Short path: decided at the start edge; skips CALC/FIX; result and done registered at edge 1; busy never rises.
  - Divide by zero (b=0): DIV/DIVU result = all-ones; REM/REMU result = a.
  - Signed overflow (DIV/REM, a=100..0, b=all-ones): DIV result = a; REM result = 0.
  - FAST_MUL=1: all multiply ops.
  - Invalid op code: result = 0.
- start while busy=1: ignored, with no effect on the running operation.
- start in the done cycle: accepted (back-to-back operation).
- flush:
  - Any state: next state IDLE, busy=0, no done; result keeps its previous value.
  - flush and start together in IDLE: flush wins and start is dropped.
- a, b and op need only be stable at the start edge; they are not observed afterwards.

Decomposition:
- ALU_* codes and F3_* constants stay in defines.v.
- Add MD_IDLE, MD_CALC and MD_FIX state encodings (2-bit) to defines.v.
- One sub-module is natural: muldiv_negate (parametrised width, conditional two's-complement). Instantiate it for operand abs at start and for the result fix in FIX.
- Everything else stays in muldiv_unit.

Test Plan:
- XLEN=32. MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB. done exactly once, after edge 34. busy high for 33 cycles. start reissued while busy is ignored.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF. Repeat with FAST_MUL=1: same values, done after edge 1.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2. Second start in the done cycle is accepted.
- DIV 5/0 -> 0xFFFFFFFF. REMU 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM of the same operands -> 0. All four: done after edge 1, busy stays 0.
- flush at edge 10 of a DIVU -> busy 0 next cycle, no done, result unchanged. rst asserted mid-CALC -> busy, done, result 0 immediately (async). Next start runs normally.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: ALU operation codes,
// FSM state encodings and the operation decode helper.
package muldiv_unit_pkg;

    localparam logic [4:0] ALU_MUL    = 5'd10;
    localparam logic [4:0] ALU_MULH   = 5'd11;
    localparam logic [4:0] ALU_MULHSU = 5'd12;
    localparam logic [4:0] ALU_MULHU  = 5'd13;
    localparam logic [4:0] ALU_DIV    = 5'd14;
    localparam logic [4:0] ALU_DIVU   = 5'd15;
    localparam logic [4:0] ALU_REM    = 5'd16;
    localparam logic [4:0] ALU_REMU   = 5'd17;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

    typedef struct packed {
        logic valid;
        logic mul;
        logic high;
        logic rem;
        logic a_signed;
        logic b_signed;
    } md_ctrl_t;

    function automatic md_ctrl_t md_decode(input logic [4:0] op);
        md_ctrl_t c;
        c = '0;
        c.valid = 1'b1;
        case (op)
            ALU_MUL: begin
                c.mul = 1'b1;
                c.a_signed = 1'b1;
                c.b_signed = 1'b1;
            end
            ALU_MULH: begin
                c.mul = 1'b1;
                c.high = 1'b1;
                c.a_signed = 1'b1;
                c.b_signed = 1'b1;
            end
            ALU_MULHSU: begin
                c.mul = 1'b1;
                c.high = 1'b1;
                c.a_signed = 1'b1;
            end
            ALU_MULHU: begin
                c.mul = 1'b1;
                c.high = 1'b1;
            end
            ALU_DIV: begin
                c.a_signed = 1'b1;
                c.b_signed = 1'b1;
            end
            ALU_DIVU: ;
            ALU_REM: begin
                c.rem = 1'b1;
                c.a_signed = 1'b1;
                c.b_signed = 1'b1;
            end
            ALU_REMU: c.rem = 1'b1;
            default: c.valid = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negation of a W-bit value.
// Ports: val_i value in, neg_i negate when high, val_o result.
module muldiv_negate #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] val_o
);

    assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (shift-add multiply, restoring divide).
// Ports: clk, rst (async active-low), start/op/a/b request, flush abort,
// busy while running, done one-cycle pulse, result registered value.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic [XLEN-1:0] res_q, res_d;
    logic mul_q, mul_d;
    logic high_q, high_d;
    logic is_rem_q, is_rem_d;
    logic neg_q, neg_d;
    logic done_q, done_d;

    md_ctrl_t ctrl;
    logic sign_a, sign_b;
    logic [XLEN-1:0] abs_a, abs_b;
    logic b_zero, ovf;

    assign ctrl   = md_decode(op);
    assign sign_a = ctrl.a_signed & a[XLEN-1];
    assign sign_b = ctrl.b_signed & b[XLEN-1];
    assign b_zero = (b == '0);
    assign ovf    = ctrl.valid & ~ctrl.mul & ctrl.a_signed
                  & (a == SMIN) & (b == '1);

    muldiv_negate #(.W(XLEN)) u_abs_a (
        .val_i(a),
        .neg_i(sign_a),
        .val_o(abs_a)
    );

    muldiv_negate #(.W(XLEN)) u_abs_b (
        .val_i(b),
        .neg_i(sign_b),
        .val_o(abs_b)
    );

    // Single-cycle path: the low 2*XLEN bits of a product of sign/zero
    // extended operands are exact for every multiply flavour.
    logic [2*XLEN-1:0] ext_a, ext_b, fast_p;
    logic [XLEN-1:0] fast_r;

    assign ext_a  = {{XLEN{sign_a}}, a};
    assign ext_b  = {{XLEN{sign_b}}, b};
    assign fast_p = ext_a * ext_b;
    assign fast_r = ctrl.high ? fast_p[2*XLEN-1:XLEN] : fast_p[XLEN-1:0];

    // Multiply step: upper half accumulates the multiplicand while the
    // multiplier shifts out of the lower half.
    logic [XLEN:0] msum;
    logic [2*XLEN-1:0] mul_next;

    assign msum = {1'b0, acc_q[2*XLEN-1:XLEN]}
                + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next = {msum, acc_q[XLEN-1:1]};

    // Divide step: upper half is the partial remainder, lower half shifts
    // the dividend out and the quotient in.
    logic [XLEN:0] shifted, diff;
    logic qbit;
    logic [XLEN-1:0] new_rem;
    logic [2*XLEN-1:0] div_next;

    assign shifted  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign diff     = shifted - {1'b0, opb_q};
    assign qbit     = ~diff[XLEN];
    assign new_rem  = qbit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    assign div_next = {new_rem, acc_q[XLEN-2:0], qbit};

    logic [2*XLEN-1:0] fix_in, fix_out;
    logic [XLEN-1:0] fix_res;

    always_comb begin
        fix_in = {{XLEN{1'b0}}, acc_q[XLEN-1:0]};
        if (mul_q) begin
            fix_in = acc_q;
        end else if (is_rem_q) begin
            fix_in = {{XLEN{1'b0}}, acc_q[2*XLEN-1:XLEN]};
        end
    end

    muldiv_negate #(.W(2*XLEN)) u_fix (
        .val_i(fix_in),
        .neg_i(neg_q),
        .val_o(fix_out)
    );

    assign fix_res = (mul_q & high_q) ? fix_out[2*XLEN-1:XLEN]
                                      : fix_out[XLEN-1:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        res_d    = res_q;
        mul_d    = mul_q;
        high_d   = high_q;
        is_rem_d = is_rem_q;
        neg_d    = neg_q;
        done_d   = 1'b0;
        if (flush) begin
            state_d = MD_IDLE;
        end else begin
            unique case (state_q)
                MD_IDLE: begin
                    if (start) begin
                        unique case (1'b1)
                            !ctrl.valid: begin
                                res_d  = '0;
                                done_d = 1'b1;
                            end
                            ctrl.valid && !ctrl.mul && b_zero: begin
                                res_d  = ctrl.rem ? a : '1;
                                done_d = 1'b1;
                            end
                            ovf: begin
                                res_d  = ctrl.rem ? '0 : a;
                                done_d = 1'b1;
                            end
                            FAST_MUL && ctrl.mul: begin
                                res_d  = fast_r;
                                done_d = 1'b1;
                            end
                            default: begin
                                state_d  = MD_CALC;
                                cnt_d    = '0;
                                acc_d    = {{XLEN{1'b0}}, abs_a};
                                opb_d    = abs_b;
                                mul_d    = ctrl.mul;
                                high_d   = ctrl.high;
                                is_rem_d = ctrl.rem;
                                neg_d    = ctrl.rem ? sign_a : (sign_a ^ sign_b);
                            end
                        endcase
                    end
                end
                MD_CALC: begin
                    acc_d = mul_q ? mul_next : div_next;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = MD_FIX;
                    end
                end
                MD_FIX: begin
                    res_d   = fix_res;
                    done_d  = 1'b1;
                    state_d = MD_IDLE;
                end
                default: state_d = MD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            res_q    <= '0;
            mul_q    <= 1'b0;
            high_q   <= 1'b0;
            is_rem_q <= 1'b0;
            neg_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            res_q    <= res_d;
            mul_q    <= mul_d;
            high_q   <= high_d;
            is_rem_q <= is_rem_d;
            neg_q    <= neg_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q != MD_IDLE);
    assign done   = done_q;
    assign result = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: iterative and FAST_MUL instances,
// compared against an arithmetic reference model.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0;
    logic startf = 1'b0;
    logic flush = 1'b0;
    logic [4:0] op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic busy0, done0, busyf, donef;
    logic [31:0] res0, resf;

    int checks = 0;
    int failures = 0;
    logic [31:0] last_res [2];
    logic [4:0] ops [8] = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                            ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(XLEN), .FAST_MUL(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy0), .done(done0), .result(res0)
    );

    muldiv_unit #(.XLEN(XLEN), .FAST_MUL(1'b1)) dutf (
        .clk(clk), .rst(rst), .start(startf), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busyf), .done(donef), .result(resf)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_mul(input logic [4:0] o);
        return o inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
    endfunction

    function automatic bit is_valid(input logic [4:0] o);
        return o inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                         ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

    function automatic bit is_ovf(input logic [4:0] o, input logic [31:0] x,
                                  input logic [31:0] y);
        return (o == ALU_DIV || o == ALU_REM)
            && x == 32'h8000_0000 && y == 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] md_ref(input logic [4:0] o,
                                           input logic [31:0] x,
                                           input logic [31:0] y);
        longint sx, sy, ux, uy;
        logic [63:0] p;
        sx = longint'(signed'(x));
        sy = longint'(signed'(y));
        ux = longint'(x);
        uy = longint'(y);
        case (o)
            ALU_MUL: begin
                p = sx * sy;
                return p[31:0];
            end
            ALU_MULH: begin
                p = sx * sy;
                return p[63:32];
            end
            ALU_MULHSU: begin
                p = sx * uy;
                return p[63:32];
            end
            ALU_MULHU: begin
                p = ux * uy;
                return p[63:32];
            end
            ALU_DIV: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (is_ovf(o, x, y)) return x;
                return $signed(x) / $signed(y);
            end
            ALU_REM: begin
                if (y == 0) return x;
                if (is_ovf(o, x, y)) return 32'd0;
                return $signed(x) % $signed(y);
            end
            ALU_DIVU: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            ALU_REMU: return (y == 0) ? x : x % y;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit is_short(input bit fast, input logic [4:0] o,
                                    input logic [31:0] x,
                                    input logic [31:0] y);
        return !is_valid(o) || (!is_mul(o) && y == 0)
            || is_ovf(o, x, y) || (fast && is_mul(o));
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic drive(input bit fast, input logic [4:0] o,
                         input logic [31:0] x, input logic [31:0] y);
        op = o;
        a = x;
        b = y;
        if (fast) startf = 1'b1;
        else start0 = 1'b1;
    endtask

    task automatic run_op(input string tag, input bit fast,
                          input logic [4:0] o, input logic [31:0] x,
                          input logic [31:0] y, input bit pre,
                          input bit poke, input bit chain,
                          input logic [4:0] o2, input logic [31:0] x2,
                          input logic [31:0] y2);
        logic [31:0] exp_r, dr;
        int bc, dc, de;
        bit sh;
        exp_r = md_ref(o, x, y);
        sh = is_short(fast, o, x, y);
        bc = 0;
        dc = 0;
        de = -1;
        dr = last_res[fast];
        if (!pre) drive(fast, o, x, y);
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) begin
                start0 = 1'b0;
                startf = 1'b0;
            end
            if (fast ? busyf : busy0) bc++;
            if (fast ? donef : done0) begin
                dc++;
                de = n;
                dr = fast ? resf : res0;
                if (chain) begin
                    drive(fast, o2, x2, y2);
                    break;
                end
            end
            if (poke && n == 5) drive(fast, ALU_DIVU, ~x, 32'd3);
            if (poke && n == 7) begin
                start0 = 1'b0;
                startf = 1'b0;
            end
        end
        chk({tag, ".res"}, dr, exp_r);
        chk({tag, ".ndone"}, dc, 1);
        chk({tag, ".tdone"}, de, sh ? 1 : XLEN + 2);
        chk({tag, ".busy"}, bc, sh ? 0 : XLEN + 1);
        last_res[fast] = exp_r;
    endtask

    task automatic rop(input string tag, input bit fast, input logic [4:0] o,
                       input logic [31:0] x, input logic [31:0] y);
        run_op(tag, fast, o, x, y, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int dc;
        last_res[0] = '0;
        last_res[1] = '0;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", busy0, 0);
        chk("rst.done", done0, 0);
        chk("rst.res", res0, 0);
        chk("rst.busyf", busyf, 0);
        chk("rst.resf", resf, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        run_op("mul", 0, ALU_MUL, 32'd7, 32'hFFFF_FFFD, 0, 1, 0, '0, '0, '0);
        rop("mulh", 0, ALU_MULH, 32'h8000_0000, 32'h8000_0000);
        rop("mulhu", 0, ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rop("mulhsu", 0, ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rop("fmul", 1, ALU_MUL, 32'd7, 32'hFFFF_FFFD);
        rop("fmulh", 1, ALU_MULH, 32'h8000_0000, 32'h8000_0000);
        rop("fmulhu", 1, ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rop("fmulhsu", 1, ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        rop("div0", 0, ALU_DIV, 32'd5, 32'd0);
        rop("remu0", 0, ALU_REMU, 32'd5, 32'd0);
        rop("divovf", 0, ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        rop("removf", 0, ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF);
        rop("badop", 0, 5'd3, 32'd9, 32'd9);

        rop("div", 0, ALU_DIV, 32'hFFFF_FFF9, 32'd2);
        rop("rem", 0, ALU_REM, 32'hFFFF_FFF9, 32'd2);
        run_op("divu", 0, ALU_DIVU, 32'd100, 32'd7, 0, 0, 1,
               ALU_REMU, 32'd100, 32'd7);
        run_op("remu", 0, ALU_REMU, 32'd100, 32'd7, 1, 0, 0, '0, '0, '0);

        dc = 0;
        drive(0, ALU_DIVU, 32'd1000, 32'd7);
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) start0 = 1'b0;
            if (n == 9) begin
                chk("flush.busy_pre", busy0, 1);
                flush = 1'b1;
            end
            if (n == 10) begin
                flush = 1'b0;
                chk("flush.busy", busy0, 0);
            end
            if (done0) dc++;
        end
        chk("flush.ndone", dc, 0);
        chk("flush.res", res0, last_res[0]);

        drive(0, ALU_DIV, 32'hFFFF_FF00, 32'd5);
        for (int n = 1; n <= 5; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) start0 = 1'b0;
        end
        chk("arst.busy_pre", busy0, 1);
        rst = 1'b0;
        #1;
        chk("arst.busy", busy0, 0);
        chk("arst.done", done0, 0);
        chk("arst.res", res0, 0);
        #1 rst = 1'b1;
        last_res[0] = '0;
        @(posedge clk);
        #1;
        rop("post_rst", 0, ALU_MULHSU, 32'h8765_4321, 32'hFEDC_BA98);

        for (int i = 0; i < 60; i++) begin
            bit f;
            int k;
            logic [4:0] o;
            f = 1'($urandom_range(0, 1));
            k = $urandom_range(0, 8);
            o = (k == 8) ? 5'd3 : ops[k];
            rop($sformatf("rnd%0d", i), f, o, pick(), pick());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
